mult_stream: RTL and testbench

MULT_STREAM -- requirements
Module: mult_stream

---
 rtl/mult_stream.sv | 157 +++++++++++++++
 tb/tb_mult_stream.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mult_stream.sv
// Batch multiplier: an input FIFO of {A,B} pairs feeds an unsigned multiplier whose products fill an output FIFO, sequenced by an IDLE/INPUT/EXEC/OUTPUT FSM.
// Define MULT_STREAM_PIPE_EN to add a second register stage after the multiplier (latency 2 instead of 1).
module mult_stream #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8,
    parameter int DEPTH   = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START,
    input  logic                       HALT,
    input  logic [A_WIDTH-1:0]         A,
    input  logic [B_WIDTH-1:0]         B,
    input  logic                       ACK,
    output logic                       REQ_AB,
    output logic [A_WIDTH+B_WIDTH-1:0] X,
    output logic                       X_VALID,
    input  logic                       X_READY,
    output logic [1:0]                 STATE,
    output logic                       OVER
);
    localparam int XW = A_WIDTH + B_WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
`ifdef MULT_STREAM_PIPE_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INPUT  = 2'd1,
        S_EXEC   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [XW-1:0] r_in_mem [DEPTH];
    logic [PW-1:0] r_in_wp, r_in_rp;
    logic [CW-1:0] r_in_cnt;
    logic [CW-1:0] r_acc_cnt;

    logic [XW-1:0] r_out_mem [DEPTH];
    logic [PW-1:0] r_out_wp, r_out_rp;
    logic [CW-1:0] r_out_cnt;

    logic [STAGES-1:0] r_vld;
    logic [XW-1:0]     r_prod [STAGES];
    logic              r_over;

    logic          w_in_wr, w_in_rd, w_in_full, w_in_empty;
    logic          w_out_wr, w_out_rd, w_out_empty;
    logic          w_start_acc;
    logic [1:0]    w_inflight;
    logic [CW:0]   w_occ;
    logic [XW-1:0] w_head, w_prod;

    assign w_in_full   = (r_in_cnt == FULL_CNT);
    assign w_in_empty  = (r_in_cnt == '0);
    assign w_out_empty = (r_out_cnt == '0);
    assign w_start_acc = (r_state == S_IDLE) && START && !HALT;

    assign REQ_AB  = (r_state == S_INPUT) && !w_in_full;
    assign X_VALID = (r_state == S_OUTPUT) && !w_out_empty;
    assign X       = X_VALID ? r_out_mem[r_out_rp] : '0;
    assign STATE   = r_state;
    assign OVER    = r_over;

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < STAGES; k++) w_inflight = w_inflight + 2'(r_vld[k]);
    end

    // Occupancy includes products still in the multiplier so the output FIFO can never overflow.
    assign w_occ    = {1'b0, r_out_cnt} + (CW+1)'(w_inflight);
    assign w_in_wr  = REQ_AB && ACK && !HALT;
    assign w_in_rd  = ((r_state == S_INPUT) || (r_state == S_EXEC)) && !w_in_empty
                      && (w_occ < (CW+1)'(DEPTH)) && !HALT;
    assign w_out_wr = r_vld[STAGES-1] && !HALT;
    assign w_out_rd = X_VALID && X_READY && !HALT;

    assign w_head = r_in_mem[r_in_rp];
    assign w_prod = XW'(w_head[XW-1:B_WIDTH]) * XW'(w_head[B_WIDTH-1:0]);

    always_comb begin
        w_state_nxt = r_state;
        if (HALT) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (START) w_state_nxt = S_INPUT;
                // The FIFO drains while filling, so batch completion counts accepted pairs.
                S_INPUT:  if (w_in_wr && (r_acc_cnt == CW'(DEPTH - 1))) w_state_nxt = S_EXEC;
                S_EXEC:   if (w_in_empty && (w_inflight == '0) && (r_out_cnt == FULL_CNT))
                              w_state_nxt = S_OUTPUT;
                S_OUTPUT: if (w_out_empty || (w_out_rd && (r_out_cnt == CW'(1))))
                              w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_over    <= 1'b0;
            r_in_wp   <= '0;
            r_in_rp   <= '0;
            r_in_cnt  <= '0;
            r_acc_cnt <= '0;
            r_out_wp  <= '0;
            r_out_rp  <= '0;
            r_out_cnt <= '0;
            r_vld     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (ACK && !REQ_AB)   r_over <= 1'b1;
            else if (w_start_acc) r_over <= 1'b0;

            if (HALT) begin
                r_in_wp   <= '0;
                r_in_rp   <= '0;
                r_in_cnt  <= '0;
                r_acc_cnt <= '0;
                r_out_wp  <= '0;
                r_out_rp  <= '0;
                r_out_cnt <= '0;
                r_vld     <= '0;
            end else begin
                if (w_in_wr) r_in_wp <= r_in_wp + PW'(1);
                if (w_in_rd) r_in_rp <= r_in_rp + PW'(1);
                r_in_cnt <= r_in_cnt + CW'(w_in_wr) - CW'(w_in_rd);

                if (w_start_acc)  r_acc_cnt <= '0;
                else if (w_in_wr) r_acc_cnt <= r_acc_cnt + CW'(1);

                if (w_out_wr) r_out_wp <= r_out_wp + PW'(1);
                if (w_out_rd) r_out_rp <= r_out_rp + PW'(1);
                r_out_cnt <= r_out_cnt + CW'(w_out_wr) - CW'(w_out_rd);

                r_vld[0] <= w_in_rd;
                for (int k = 1; k < STAGES; k++) r_vld[k] <= r_vld[k-1];
            end
        end
    end

    // Data storage carries no reset; validity is tracked by the counters and valid bits.
    always_ff @(posedge CLK) begin
        if (w_in_wr) r_in_mem[r_in_wp] <= {A, B};
        if (w_out_wr) r_out_mem[r_out_wp] <= r_prod[STAGES-1];
        if (w_in_rd) r_prod[0] <= w_prod;
        for (int k = 1; k < STAGES; k++) r_prod[k] <= r_prod[k-1];
    end
endmodule

// File: tb/tb_mult_stream.sv
// Self-checking bench for mult_stream: vector table of batches, scoreboard of expected products, corner-case sequences.
module tb_mult_stream;
    localparam int AW    = 8;
    localparam int BW    = 8;
    localparam int XW    = AW + BW;
    localparam int DEPTH = 16;

    logic          CLK = 1'b0;
    logic          RST, START, HALT, ACK, X_READY;
    logic [AW-1:0] A;
    logic [BW-1:0] B;
    logic          REQ_AB, X_VALID, OVER;
    logic [XW-1:0] X;
    logic [1:0]    STATE;

    mult_stream #(.A_WIDTH(AW), .B_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .START(START), .HALT(HALT), .A(A), .B(B), .ACK(ACK),
        .REQ_AB(REQ_AB), .X(X), .X_VALID(X_VALID), .X_READY(X_READY),
        .STATE(STATE), .OVER(OVER)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [XW-1:0] x;
    } vec_t;

    vec_t          tbl [3*DEPTH];
    logic [XW-1:0] sb [$];
    int            checks = 0;
    int            errors = 0;
    int            n_out  = 0;
    bit            stall  = 0;
    logic [XW-1:0] hold;
    bit            pat [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: transfers happen on the next rising edge when X_VALID && X_READY.
    always @(negedge CLK) begin
        if (RST && !HALT) begin
            if (X_VALID && X_READY) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL x_extra: got %0d expected no transfer", X);
                end else begin
                    logic [XW-1:0] e;
                    e = sb.pop_front();
                    checks--;
                    chk("x_data", 32'(X), 32'(e));
                end
                n_out++;
            end
            if (stall && X_VALID) chk("x_hold", 32'(X), 32'(hold));
            if (!X_VALID) chk("x_zero", 32'(X), 32'd0);
            stall = X_VALID && !X_READY;
            hold  = X;
        end else begin
            stall = 0;
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_batch();
        START = 1'b1;
        cyc();
        START = 1'b0;
        chk("state_input", 32'(STATE), 32'd1);
        chk("over_clear", 32'(OVER), 32'd0);
    endtask

    task automatic feed(input int base, input int n, input bit push);
        for (int i = 0; i < n; i++) begin
            A   = tbl[base+i].a;
            B   = tbl[base+i].b;
            ACK = 1'b1;
            #1 chk("req_ab", 32'(REQ_AB), 32'd1);
            if (push) sb.push_back(tbl[base+i].x);
            cyc();
        end
        ACK = 1'b0;
    endtask

    task automatic run_batch(input int base, input bit stall_mode);
        int t;
        int k;
        n_out = 0;
        start_batch();
        feed(base, DEPTH, 1'b1);
        chk("state_exec", 32'(STATE), 32'd2);
        t = 0;
        while (STATE != 2'd3 && t < 200) begin cyc(); t++; end
        chk("reach_output", 32'(STATE), 32'd3);
        k = 0;
        while (STATE != 2'd0 && t < 400) begin
            X_READY = stall_mode ? pat[k%4] : 1'b1;
            k++;
            cyc();
            t++;
        end
        X_READY = 1'b1;
        chk("back_idle", 32'(STATE), 32'd0);
        chk("n_out", 32'(n_out), 32'(DEPTH));
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < DEPTH; i++) begin
            tbl[i].a = AW'(i + 1);
            tbl[i].b = BW'(2);
            tbl[DEPTH+i].a = '1;
            tbl[DEPTH+i].b = '1;
            tbl[2*DEPTH+i].a = AW'($urandom);
            tbl[2*DEPTH+i].b = BW'($urandom);
        end
        for (int j = 0; j < 3*DEPTH; j++)
            tbl[j].x = {{BW{1'b0}}, tbl[j].a} * {{AW{1'b0}}, tbl[j].b};

        RST = 1'b0; START = 1'b0; HALT = 1'b0; ACK = 1'b0; X_READY = 1'b1;
        A = '0; B = '0;
        cyc(); cyc();
        chk("rst_state", 32'(STATE), 32'd0);
        chk("rst_req_ab", 32'(REQ_AB), 32'd0);
        chk("rst_x_valid", 32'(X_VALID), 32'd0);
        chk("rst_x", 32'(X), 32'd0);
        chk("rst_over", 32'(OVER), 32'd0);
        RST = 1'b1;
        cyc();

        // START together with HALT in IDLE stays in IDLE
        START = 1'b1; HALT = 1'b1;
        cyc();
        START = 1'b0; HALT = 1'b0;
        chk("start_halt_idle", 32'(STATE), 32'd0);

        run_batch(0, 1'b0);
        run_batch(DEPTH, 1'b0);
        chk("max_product", 32'(tbl[DEPTH].x), 32'h0000_FE01);
        run_batch(2*DEPTH, 1'b1);

        // ACK while not requesting: no write, sticky OVER until next START
        A = 3; B = 3; ACK = 1'b1;
        cyc();
        ACK = 1'b0;
        chk("over_set", 32'(OVER), 32'd1);
        cyc(); cyc(); cyc();
        chk("over_sticky", 32'(OVER), 32'd1);
        run_batch(0, 1'b0);

        // HALT after 7 accepted pairs, with a simultaneous ACK that must be dropped
        start_batch();
        feed(DEPTH, 7, 1'b0);
        A = 9; B = 9; ACK = 1'b1; HALT = 1'b1;
        cyc();
        ACK = 1'b0; HALT = 1'b0;
        chk("halt_state", 32'(STATE), 32'd0);
        chk("halt_req_ab", 32'(REQ_AB), 32'd0);
        chk("halt_x_valid", 32'(X_VALID), 32'd0);
        run_batch(2*DEPTH, 1'b1);

        // Reset in the middle of EXEC discards everything
        start_batch();
        feed(0, DEPTH, 1'b1);
        chk("pre_rst_exec", 32'(STATE), 32'd2);
        cyc();
        RST = 1'b0;
        cyc();
        sb.delete();
        chk("mid_rst_state", 32'(STATE), 32'd0);
        chk("mid_rst_req_ab", 32'(REQ_AB), 32'd0);
        chk("mid_rst_x_valid", 32'(X_VALID), 32'd0);
        chk("mid_rst_x", 32'(X), 32'd0);
        chk("mid_rst_over", 32'(OVER), 32'd0);
        RST = 1'b1;
        cyc();
        run_batch(DEPTH, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
